// File: rtl/acq_sequencer.sv
// Acquisition trigger sequencer.
// Walks a capture through pre-trigger fill, holdoff, trigger wait and
// post-trigger fill. The FIFO address counter is told when a trigger has
// been accepted. Every output is registered and changes on the same edge
// as State.
module acq_sequencer #(
    parameter int AUTO_W = 24,
    parameter int HOLD_W = 16
) (
    input  logic              Wclk,
    input  logic              ClrW,
    input  logic              Arm,
    input  logic              Abort,
    input  logic [1:0]        Mode,
    input  logic              TrigIn,
    input  logic              ForceTrig,
    input  logic              Sampled,
    input  logic              Full,
    input  logic [AUTO_W-1:0] AutoTime,
    input  logic [HOLD_W-1:0] Holdoff,
    output logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              TrigType,
    output logic [2:0]        State
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HOLD = 3'd2,
        S_WAIT = 3'd3,
        S_POST = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              trig_in_d;
    logic              trig_type_d;
    logic              start_d, busy_d, done_d;
    logic              trig_edge;
    logic              auto_hit;

    // A level that was already high the cycle before is not a trigger.
    assign trig_edge = TrigIn & ~trig_in_d;
    // Only auto mode may time out; modes 00, 10 and 11 wait forever.
    assign auto_hit  = (Mode == 2'b01) && (auto_cnt_q == AutoTime);
    assign State     = state_q;

    // Next-state, counter and registered-output decode.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        auto_cnt_d  = auto_cnt_q;
        trig_type_d = TrigType;

        if (Abort) begin
            // Abort outranks every other transition.
            state_d     = S_IDLE;
            trig_type_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Arm) state_d = S_PRE;
                end
                S_PRE: begin
                    if (Sampled) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
                S_HOLD: begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_q == Holdoff) begin
                        state_d    = S_WAIT;
                        auto_cnt_d = '0;
                    end
                end
                S_WAIT: begin
                    if (auto_cnt_q != '1) auto_cnt_d = auto_cnt_q + AUTO_W'(1);
                    if (trig_edge || ForceTrig || auto_hit) begin
                        state_d     = S_POST;
                        // A real edge wins over a coincident force or timeout.
                        trig_type_d = ~trig_edge;
                    end
                end
                S_POST: begin
                    if (Full) state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        start_d = (state_d == S_POST) || (state_d == S_DONE);
        busy_d  = (state_d == S_PRE) || (state_d == S_HOLD) ||
                  (state_d == S_WAIT) || (state_d == S_POST);
        done_d  = (state_d == S_DONE);
    end

    // State, counters, trigger history and outputs; ClrW clears everything at once.
    always_ff @(posedge Wclk or posedge ClrW) begin
        if (ClrW) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            auto_cnt_q <= '0;
            trig_in_d  <= 1'b0;
            TrigType   <= 1'b0;
            Start      <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            auto_cnt_q <= auto_cnt_d;
            trig_in_d  <= TrigIn;
            TrigType   <= trig_type_d;
            Start      <= start_d;
            Busy       <= busy_d;
            Done       <= done_d;
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: directed scenarios followed by
// randomized traffic, all checked every cycle against a phase-level model.
module tb_acq_sequencer;

    localparam int AUTO_W = 24;
    localparam int HOLD_W = 16;
    localparam longint AUTO_MAX = (64'd1 << AUTO_W) - 1;

    logic              Wclk = 1'b0;
    logic              ClrW;
    logic              Arm, Abort, TrigIn, ForceTrig, Sampled, Full;
    logic [1:0]        Mode;
    logic [AUTO_W-1:0] AutoTime;
    logic [HOLD_W-1:0] Holdoff;
    logic              Start, Busy, Done, TrigType;
    logic [2:0]        State;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase number, holdoff cycles still to spend, cycles already
    // spent waiting, latched trigger kind, previous trigger level.
    int     m_phase;
    int     m_hold_left;
    longint m_wait_cycles;
    bit     m_forced;
    bit     m_prev_trig;

    acq_sequencer #(.AUTO_W(AUTO_W), .HOLD_W(HOLD_W)) dut (
        .Wclk      (Wclk),
        .ClrW      (ClrW),
        .Arm       (Arm),
        .Abort     (Abort),
        .Mode      (Mode),
        .TrigIn    (TrigIn),
        .ForceTrig (ForceTrig),
        .Sampled   (Sampled),
        .Full      (Full),
        .AutoTime  (AutoTime),
        .Holdoff   (Holdoff),
        .Start     (Start),
        .Busy      (Busy),
        .Done      (Done),
        .TrigType  (TrigType),
        .State     (State)
    );

    always #5 Wclk = ~Wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase       = 0;
        m_hold_left   = 0;
        m_wait_cycles = 0;
        m_forced      = 1'b0;
        m_prev_trig   = 1'b0;
    endtask

    // One clock edge of behaviour, using the inputs present at that edge.
    task automatic model_step();
        bit     rose;
        longint seen;
        rose = TrigIn && !m_prev_trig;
        seen = (m_wait_cycles > AUTO_MAX) ? AUTO_MAX : m_wait_cycles;
        if (Abort) begin
            m_phase  = 0;
            m_forced = 1'b0;
        end else begin
            case (m_phase)
                0: if (Arm) m_phase = 1;
                1: if (Sampled) begin
                       m_phase     = 2;
                       m_hold_left = int'(Holdoff) + 1;
                   end
                2: begin
                       m_hold_left--;
                       if (m_hold_left == 0) begin
                           m_phase       = 3;
                           m_wait_cycles = 0;
                       end
                   end
                3: begin
                       if (rose || ForceTrig || (Mode == 2'b01 && seen == longint'(AutoTime))) begin
                           m_phase  = 4;
                           m_forced = !rose;
                       end else begin
                           m_wait_cycles++;
                       end
                   end
                4: if (Full) m_phase = 5;
                default: ;
            endcase
        end
        m_prev_trig = TrigIn;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"}, 32'(State), 32'(m_phase));
        check({tag, ".start"}, 32'(Start), 32'(m_phase == 4 || m_phase == 5));
        check({tag, ".busy"},  32'(Busy),  32'(m_phase >= 1 && m_phase <= 4));
        check({tag, ".done"},  32'(Done),  32'(m_phase == 5));
        check({tag, ".ttype"}, 32'(TrigType), 32'(m_forced));
    endtask

    task automatic tick();
        @(posedge Wclk);
        model_step();
        #1;
        compare_all("cyc");
    endtask

    // Assert ClrW away from any clock edge and check that it acts at once.
    task automatic do_reset();
        ClrW = 1'b1;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge Wclk);
        ClrW = 1'b0;
    endtask

    task automatic quiet_inputs();
        Arm = 1'b0; Abort = 1'b0; ForceTrig = 1'b0; Sampled = 1'b0; Full = 1'b0;
    endtask

    task automatic abort_to_idle();
        quiet_inputs();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
    endtask

    task automatic go_to_wait();
        Arm = 1'b1;     tick(); Arm = 1'b0;
        Sampled = 1'b1; tick(); Sampled = 1'b0;
        repeat (int'(Holdoff) + 1) tick();
        check("reach_wait", 32'(State), 32'd3);
    endtask

    initial begin
        int hold_cycles;
        int start_cyc;
        int n;

        ClrW = 1'b1; TrigIn = 1'b0; Mode = 2'b00;
        AutoTime = 24'd100; Holdoff = 16'd3;
        quiet_inputs();
        model_reset();
        do_reset();

        // Normal path with Holdoff=3.
        hold_cycles = 0;
        start_cyc   = -1;
        for (int cyc = 0; cyc <= 60; cyc++) begin
            Arm     = (cyc == 0);
            Sampled = (cyc >= 10);
            TrigIn  = (cyc >= 30);
            Full    = (cyc >= 50);
            tick();
            if (State == 3'd2) hold_cycles++;
            if (Start && start_cyc < 0) start_cyc = cyc;
        end
        check("norm_hold_len",  32'(hold_cycles), 32'd4);
        check("norm_start_cyc", 32'(start_cyc), 32'd30);
        check("norm_ttype",     32'(TrigType), 32'd0);
        check("norm_done",      32'(Done), 32'd1);
        abort_to_idle();
        TrigIn = 1'b0;

        // Auto timeout after exactly AutoTime+1 waiting cycles.
        Mode = 2'b01; AutoTime = 24'd100; Holdoff = 16'd0;
        go_to_wait();
        n = 0;
        while (State == 3'd3 && n < 200) begin
            tick();
            n++;
        end
        check("auto_wait_len", 32'(n), 32'd101);
        check("auto_state",    32'(State), 32'd4);
        check("auto_ttype",    32'(TrigType), 32'd1);
        abort_to_idle();

        // AutoTime=0 fires on the first waiting cycle.
        AutoTime = 24'd0;
        go_to_wait();
        tick();
        check("auto_zero_state", 32'(State), 32'd4);
        check("auto_zero_ttype", 32'(TrigType), 32'd1);
        abort_to_idle();

        // Modes 10 and 11 never time out.
        AutoTime = 24'd5;
        for (int m = 2; m <= 3; m++) begin
            Mode = 2'(m);
            go_to_wait();
            repeat (30) tick();
            check("no_timeout", 32'(State), 32'd3);
            abort_to_idle();
        end

        // Trigger level held high from reset must not fire until re-raised.
        Mode = 2'b00; Holdoff = 16'd2; TrigIn = 1'b1;
        do_reset();
        go_to_wait();
        repeat (20) tick();
        check("preheld_wait", 32'(State), 32'd3);
        TrigIn = 1'b0; tick();
        check("preheld_drop", 32'(State), 32'd3);
        TrigIn = 1'b1; tick();
        check("preheld_fire", 32'(State), 32'd4);
        check("preheld_ttype", 32'(TrigType), 32'd0);

        // Abort together with Full in POST.
        Abort = 1'b1; Full = 1'b1; tick();
        quiet_inputs();
        check("abort_full_state", 32'(State), 32'd0);
        check("abort_full_start", 32'(Start), 32'd0);
        check("abort_full_done",  32'(Done), 32'd0);
        TrigIn = 1'b0;

        // Edge and force on the same cycle: edge wins. Then Arm in DONE.
        go_to_wait();
        TrigIn = 1'b1; ForceTrig = 1'b1; tick();
        ForceTrig = 1'b0;
        check("simul_ttype", 32'(TrigType), 32'd0);
        Full = 1'b1; tick(); Full = 1'b0;
        Arm = 1'b1; repeat (3) tick(); Arm = 1'b0;
        check("arm_in_done", 32'(State), 32'd5);
        abort_to_idle();
        TrigIn = 1'b0;

        // Trigger activity in PRE and HOLD is ignored.
        Holdoff = 16'd4;
        Arm = 1'b1; tick(); Arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            TrigIn = i[0]; ForceTrig = i[1]; Full = 1'b1;
            tick();
        end
        quiet_inputs();
        check("pre_ignore", 32'(State), 32'd1);
        TrigIn = 1'b0;
        Sampled = 1'b1; tick(); Sampled = 1'b0;
        for (int i = 0; i < 5; i++) begin
            TrigIn = i[0];
            tick();
            check("hold_ignore", 32'(State), (i < 4) ? 32'd2 : 32'd3);
        end

        // ClrW mid-acquisition, then a fresh Arm.
        ForceTrig = 1'b1; tick(); ForceTrig = 1'b0;
        check("pre_clr_post", 32'(State), 32'd4);
        do_reset();
        check("clr_start", 32'(Start), 32'd0);
        Arm = 1'b1; tick(); Arm = 1'b0;
        check("clr_rearm", 32'(State), 32'd1);

        // Randomized traffic.
        for (int s = 0; s < 40; s++) begin
            abort_to_idle();
            Mode     = 2'($urandom_range(0, 3));
            Holdoff  = HOLD_W'($urandom_range(0, 5));
            AutoTime = AUTO_W'($urandom_range(0, 20));
            for (int c = 0; c < 50; c++) begin
                Arm       = ($urandom_range(0, 3) == 0);
                Sampled   = ($urandom_range(0, 3) == 0);
                Full      = ($urandom_range(0, 3) == 0);
                ForceTrig = ($urandom_range(0, 15) == 0);
                Abort     = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 5) == 0) TrigIn = ~TrigIn;
                if ($urandom_range(0, 149) == 0) do_reset();
                else tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter AUTO_W, default 24: auto-trigger timeout counter width.
REQ-002 Parameter HOLD_W, default 16: holdoff counter width.
REQ-003 ClrW  in  1  asynchronous active-high reset; re-arm of the capture chain is always by ClrW.
REQ-004 Wclk  in  1  clock; all logic is rising-edge, single clock domain.
REQ-005 Arm  in  1  start acquisition; sampled in IDLE only.
REQ-006 Abort  in  1  synchronous return to IDLE.
REQ-007 Mode  in  2  trigger mode:
- 00 normal
- 01 auto
- 10 single
- 11 treated as normal
REQ-008 TrigIn  in  1  synchronous trigger level; rising edge qualifies.
REQ-009 ForceTrig  in  1  software forced trigger, level sampled per cycle.
REQ-010 Sampled  in  1  pre-trigger depth reached, from the FIFO address counter.
REQ-011 Full  in  1  post-trigger capture complete, from the FIFO address counter.
REQ-012 AutoTime  in  AUTO_W  auto-mode timeout in cycles.
REQ-013 Holdoff  in  HOLD_W  cycles spent in HOLD minus one.
REQ-014 Start  out  1  trigger-accepted strobe to the FIFO address counter; level.
REQ-015 Busy  out  1  acquisition in progress.
REQ-016 Done  out  1  capture complete.
REQ-017 TrigType  out  1  0 = TrigIn edge, 1 = forced (ForceTrig or auto timeout).
REQ-018 State  out  3  current state encoding.

Function
REQ-019 State encoding SHALL be: IDLE=0, PRE=1, HOLD=2, WAIT=3, POST=4, DONE=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-020 All state and output changes SHALL be registered; outputs SHALL update on the same edge as State.
REQ-021 IDLE: Arm=1 SHALL move the block to PRE; otherwise the block stays in IDLE.
REQ-022 PRE: Sampled=1 SHALL move the block to HOLD and clear the holdoff counter; TrigIn edges, ForceTrig and Full SHALL be ignored.
REQ-023 HOLD: the holdoff counter SHALL increment each cycle; counter==Holdoff SHALL move the block to WAIT, so HOLD lasts Holdoff+1 cycles (Holdoff=0 gives 1 cycle).
REQ-024 WAIT entry SHALL clear the auto counter; the counter SHALL increment each WAIT cycle and saturate at all-ones.
REQ-025 Edge detect: TrigIn_d SHALL be registered every cycle in every state; edge = TrigIn & ~TrigIn_d.
- A level already high before WAIT SHALL NOT trigger.
REQ-026 WAIT exit: the block SHALL leave WAIT for POST when any of the following is true in a cycle:
- edge=1
- ForceTrig=1
- Mode=01 and auto counter==AutoTime
REQ-027 On that edge the block SHALL set Start=1 and latch TrigType; edge=1 SHALL take priority, giving TrigType=0 even when a force or timeout occurs in the same cycle.
REQ-028 Mode=01 with AutoTime=0 SHALL trigger on the first WAIT cycle.
REQ-029 Modes 00 and 10 SHALL never time out.
REQ-030 POST: Full=1 SHALL move the block to DONE; Start SHALL remain 1 in both POST and DONE.
REQ-031 DONE SHALL hold until ClrW or Abort; Arm SHALL be ignored in DONE.
REQ-032 Arm asserted in any state other than IDLE SHALL be ignored.
REQ-033 Abort=1 in any state SHALL move the block to IDLE with Start=0 and TrigType=0, and SHALL take priority over every other transition in the same cycle.
REQ-034 Output decode:
- Busy=1 in PRE, HOLD, WAIT and POST
- Done=1 only in DONE
- State reflects the state register

Reset
REQ-035 ClrW=1 SHALL asynchronously force:
- State=IDLE
- Start=0, Busy=0, Done=0, TrigType=0
- TrigIn_d=0
- both counters to 0
REQ-036 ClrW asserted mid-acquisition SHALL abandon the capture with no residual Start.
REQ-037 After ClrW deasserts, the first edge SHALL evaluate IDLE.

Verification
REQ-038 Normal path: Mode=00, Holdoff=3, pulse Arm, Sampled at cycle 10, TrigIn rising at cycle 30, Full at cycle 50 -> State 1,2(4 cycles),3,4,5; Start rises on the TrigIn edge +1; TrigType=0; Done=1.
REQ-039 Auto timeout: Mode=01, AutoTime=100, TrigIn held 0 -> POST exactly 101 cycles after WAIT entry, TrigType=1.
REQ-040 Pre-held trigger: TrigIn held 1 from reset through WAIT, Mode=00 -> stays in WAIT; dropping and re-raising TrigIn triggers on the re-raise +1.
REQ-041 Simultaneous events: in WAIT, drive the TrigIn edge and ForceTrig on the same cycle -> TrigType=0; Abort with Full in POST -> IDLE, Start=0, Done=0.
REQ-042 Reset mid-operation: ClrW pulsed while in POST -> all outputs 0 immediately; Arm after release -> PRE.
REQ-043 Ignored inputs: Arm in DONE and TrigIn edges in PRE/HOLD produce no state change.
